pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised fetch-stage program counter for the ARM pipeline; next generation of the bare PC register.
//  Holds the current fetch address and adds internal sequential increment, priority redirect, stall,
//  target alignment checking and ARM-visible PC (+2 instructions).
//  Adds an optional return-address stack (RAS). Feeds instruction memory and the decode stage.
// PARAMETERS
//  ADDR_W       32  PC width in bits
//  RESET_VEC    0   PC value loaded on reset (must be INSTR_BYTES-aligned)
//  INSTR_BYTES  4   bytes per instruction (power of 2: 2 or 4)
//  RAS_DEPTH    4   return-address stack entries (power of 2, >=2; used only with PC_RAS_EN)
// PORTS
//  clk              in   1       rising-edge clock
//  reset            in   1       asynchronous, active-low reset
//  enable           in   1       1 = advance PC this cycle; 0 = stall (hold)
//  redirect_valid   in   1       branch/exception redirect request
//  redirect_target  in   ADDR_W  redirect address
//  link             in   1       qualifies redirect as BL: push return address to RAS
//  ret              in   1       predicted-return request: pop RAS into PC
//  pc_current       out  ADDR_W  current fetch address
//  pc_plus_inst     out  ADDR_W  pc_current + INSTR_BYTES (combinational)
//  pc_read          out  ADDR_W  pc_current + 2*INSTR_BYTES (ARM architectural PC read)
//  misalign         out  1       sticky: a misaligned redirect target was seen
//  ret_miss         out  1       1-cycle pulse: ret requested with RAS empty
//  ras_empty        out  1       RAS holds no entries
//  ras_full         out  1       RAS holds RAS_DEPTH entries
// BEHAVIOUR
//  - Reset (reset==0, async): pc_current=RESET_VEC, misalign=0, ret_miss=0, RAS count=0
//    (ras_empty=1, ras_full=0). Reset mid-stall or mid-pop discards all state.
//  - Register updates on the rising edge; 1-cycle latency from request to new pc_current.
//  - Priority per edge: redirect_valid > ret > sequential (enable) > hold.
//  - redirect_valid: taken even when enable=0 (flush overrides stall).
//    pc_current <= redirect_target with low log2(INSTR_BYTES) bits forced to 0.
//    If those bits were nonzero, misalign <= 1 (held until reset).
//  - ret (no redirect, enable=1): see CONFIGURATION. ret while enable=0 is ignored (no pop).
//  - Sequential: enable=1, no redirect/ret -> pc_current <= pc_current + INSTR_BYTES.
//  - Hold: enable=0, no redirect -> pc_current unchanged.
//  - Arithmetic: all sums modulo 2**ADDR_W; increment from the top address wraps to 0.
//  - ret_miss is a registered pulse, high exactly one cycle after the failing request.
// CONFIGURATION
//  Macro PC_RAS_EN:
//  - Defined:
//    - Push: redirect_valid & link pushes pc_current+INSTR_BYTES (also taken when enable=0).
//    - Pop: ret & ~redirect_valid & enable & ~ras_empty -> pc_current <= top entry; count--.
//    - Pop on empty: sequential advance instead; ret_miss=1 next cycle.
//    - Push when full: overwrite the oldest entry (circular); count stays RAS_DEPTH.
//    - ret is ignored while redirect_valid=1 (no pop), including redirect_valid & link & ret.
//  - Undefined: no RAS storage; link and ret ignored; ras_empty=1, ras_full=0, ret_miss=0 constant.
// STRUCTURE
//  - Shared package pc_pkg: ADDR_W default, INSTR_BYTES default, ALIGN_BITS=$clog2(INSTR_BYTES),
//    align() function (clear low bits).
//  - One sub-module, pc_ras: circular LIFO (top pointer, count, push/pop, full/empty).
//    Instantiated only under `ifdef PC_RAS_EN.
// TESTING
//  1 Reset: hold reset=0, RESET_VEC=0x100 -> pc_current=0x100, pc_read=0x108, ras_empty=1;
//    release, enable=1 x3 -> 0x104, 0x108, 0x10C.
//  2 Stall + flush: enable=0 at pc=0x10 for 3 cycles -> pc stays 0x10; enable=0, redirect to 0x200 -> pc=0x200 next cycle.
//  3 Misalign/wrap: redirect to 0x302 -> pc=0x300, misalign=1 sticky; redirect to 0xFFFFFFFC then enable -> pc=0x0.
//  4 RAS push/pop (PC_RAS_EN): at pc=0x40, redirect 0x800 with link; enable x2 -> pc=0x808; ret -> pc=0x44, ras_empty=1.
//  5 RAS bounds: RAS_DEPTH=4, 5 link redirects -> ras_full=1, 4 pops return newest 4 addresses;
//    5th ret -> sequential advance plus ret_miss pulse.
//  6 Async reset mid-operation: assert reset between edges with 2 RAS entries -> pc=RESET_VEC
//    immediately, ras_empty=1, misalign=0.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and address alignment helper for the fetch PC
package pc_pkg;

  localparam int PC_ADDR_W      = 32;
  localparam int PC_INSTR_BYTES = 4;
  localparam int ALIGN_BITS     = $clog2(PC_INSTR_BYTES);

  // Clears the low_bits least-significant bits; callers truncate to their own width.
  function automatic logic [63:0] align(input logic [63:0] addr, input int low_bits);
    return addr & ~((64'd1 << low_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - request/status bundle between the fetch PC and its controller
interface pc_unit_if #(
  parameter int ADDR_W = pc_pkg::PC_ADDR_W
);

  logic              enable;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              link;
  logic              ret;
  logic [ADDR_W-1:0] pc_current;
  logic [ADDR_W-1:0] pc_plus_inst;
  logic [ADDR_W-1:0] pc_read;
  logic              misalign;
  logic              ret_miss;
  logic              ras_empty;
  logic              ras_full;

  modport master (
    output enable, redirect_valid, redirect_target, link, ret,
    input  pc_current, pc_plus_inst, pc_read, misalign, ret_miss, ras_empty, ras_full
  );

  modport slave (
    input  enable, redirect_valid, redirect_target, link, ret,
    output pc_current, pc_plus_inst, pc_read, misalign, ret_miss, ras_empty, ras_full
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The pointer wraps naturally, so the slot after top is the oldest entry once full.
  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d        = top_q + 1'b1;
      mem_d[top_d] = push_data;
      if (cnt_q != DEPTH_C) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop && (cnt_q != '0)) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  assign top_data = mem_q[top_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == DEPTH_C);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage PC with redirect, stall, alignment check and ARM PC read
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                INSTR_BYTES = PC_INSTR_BYTES,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.slave   bus
);

  localparam int LOW_BITS = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(2 * INSTR_BYTES);
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              ret_miss_q, ret_miss_d;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] tgt_aligned;
  logic              ras_push, ras_pop;
  logic              ras_empty, ras_full;
  logic [ADDR_W-1:0] ras_top;

  assign pc_seq      = pc_q + STEP;
  assign tgt_aligned = ADDR_W'(align(64'(bus.redirect_target), LOW_BITS));

`ifdef PC_RAS_EN
  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .push_data (pc_seq),
    .pop       (ras_pop),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign unused_ras = ras_push ^ ras_pop ^ (RAS_DEPTH > 1);
`endif

  // Redirect (flush) wins even over a stall; ret only acts on an advancing cycle.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    ret_miss_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (bus.redirect_valid) begin
      pc_d     = tgt_aligned;
      ras_push = RAS_ON && bus.link;
      if (tgt_aligned != bus.redirect_target) begin
        misalign_d = 1'b1;
      end
    end else if (bus.enable) begin
      if (RAS_ON && bus.ret && !ras_empty) begin
        ras_pop = 1'b1;
        pc_d    = ras_top;
      end else begin
        pc_d       = pc_seq;
        ret_miss_d = RAS_ON && bus.ret && ras_empty;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      ret_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      ret_miss_q <= ret_miss_d;
    end
  end

  assign bus.pc_current   = pc_q;
  assign bus.pc_plus_inst = pc_seq;
  assign bus.pc_read      = pc_q + STEP2;
  assign bus.misalign     = misalign_q;
  assign bus.ret_miss     = ret_miss_q;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - table-driven and scoreboard bench for pc_unit (either PC_RAS_EN setting)
module tb_pc_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  pc_unit_if #(.ADDR_W(32)) bif ();

  pc_unit #(
    .ADDR_W      (32),
    .RESET_VEC   (32'h100),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic        en;
    logic        rv;
    logic [31:0] tgt;
    logic        lk;
    logic        rt;
    logic [31:0] pc;
    logic        mis;
    logic        miss;
    logic        emp;
    logic        full;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[12];
  int   nchk = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic en, logic rv, logic [31:0] tgt, logic lk, logic rt,
                              logic [31:0] pc, logic mis, logic miss, logic emp, logic full);
    vec_t v;
    v.en = en; v.rv = rv; v.tgt = tgt; v.lk = lk; v.rt = rt;
    v.pc = pc; v.mis = mis; v.miss = miss; v.emp = emp; v.full = full;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t e);
    chk({tag, " pc_current"}, bif.pc_current, e.pc);
    chk({tag, " pc_plus_inst"}, bif.pc_plus_inst, e.pc + 32'd4);
    chk({tag, " pc_read"}, bif.pc_read, e.pc + 32'd8);
    chk({tag, " misalign"}, {31'd0, bif.misalign}, {31'd0, e.mis});
    chk({tag, " ret_miss"}, {31'd0, bif.ret_miss}, {31'd0, e.miss});
    chk({tag, " ras_empty"}, {31'd0, bif.ras_empty}, {31'd0, e.emp});
    chk({tag, " ras_full"}, {31'd0, bif.ras_full}, {31'd0, e.full});
  endtask

  // Drive one request, queue its expectation, pop and compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    bif.enable          = v.en;
    bif.redirect_valid  = v.rv;
    bif.redirect_target = v.tgt;
    bif.link            = v.lk;
    bif.ret             = v.rt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_out(tag, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bif.enable = 1'b0; bif.redirect_valid = 1'b0; bif.redirect_target = '0;
    bif.link = 1'b0; bif.ret = 1'b0;

    reset = 1'b0;
    #12;
    check_out("reset", mk(0, 0, 0, 0, 0, 32'h100, 0, 0, 1, 0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    //         en rv tgt            lk rt pc             mis miss emp full
    tbl[0]  = mk(1, 0, 32'h0,        0, 0, 32'h104,       0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 32'h0,        0, 0, 32'h108,       0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 32'h0,        0, 0, 32'h10C,       0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 32'h10,       0, 0, 32'h10,        0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 32'h10,        0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 32'h0,        0, 0, 32'h10,        0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 32'h0,        0, 0, 32'h10,        0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 32'h200,      0, 0, 32'h200,       0, 0, 1, 0);
    tbl[8]  = mk(1, 1, 32'h302,      0, 0, 32'h300,       1, 0, 1, 0);
    tbl[9]  = mk(1, 0, 32'h0,        0, 0, 32'h304,       1, 0, 1, 0);
    tbl[10] = mk(1, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC,  1, 0, 1, 0);
    tbl[11] = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end
    step("hold_wrap", mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 1, 0));
    step("misalign_stall", mk(0, 1, 32'h7, 0, 0, 32'h4, 1, 0, 1, 0));

`ifdef PC_RAS_EN
    step("ras_a", mk(1, 1, 32'h40, 0, 0, 32'h40, 1, 0, 1, 0));
    step("ras_bl", mk(1, 1, 32'h800, 1, 0, 32'h800, 1, 0, 0, 0));
    step("ras_seq1", mk(1, 0, 32'h0, 0, 0, 32'h804, 1, 0, 0, 0));
    step("ras_seq2", mk(1, 0, 32'h0, 0, 0, 32'h808, 1, 0, 0, 0));
    step("ras_ret", mk(1, 0, 32'h0, 0, 1, 32'h44, 1, 0, 1, 0));
    step("push1", mk(1, 1, 32'h1000, 1, 0, 32'h1000, 1, 0, 0, 0));
    step("push2", mk(1, 1, 32'h2000, 1, 0, 32'h2000, 1, 0, 0, 0));
    step("push3", mk(1, 1, 32'h3000, 1, 0, 32'h3000, 1, 0, 0, 0));
    step("push4", mk(1, 1, 32'h4000, 1, 0, 32'h4000, 1, 0, 0, 1));
    step("push5", mk(1, 1, 32'h5000, 1, 0, 32'h5000, 1, 0, 0, 1));
    step("pop1", mk(1, 0, 32'h0, 0, 1, 32'h4004, 1, 0, 0, 0));
    step("pop2", mk(1, 0, 32'h0, 0, 1, 32'h3004, 1, 0, 0, 0));
    step("pop3", mk(1, 0, 32'h0, 0, 1, 32'h2004, 1, 0, 0, 0));
    step("pop4", mk(1, 0, 32'h0, 0, 1, 32'h1004, 1, 0, 1, 0));
    step("pop_empty", mk(1, 0, 32'h0, 0, 1, 32'h1008, 1, 1, 1, 0));
    step("miss_clear", mk(1, 0, 32'h0, 0, 0, 32'h100C, 1, 0, 1, 0));
    step("bl_and_ret", mk(1, 1, 32'h600, 1, 1, 32'h600, 1, 0, 0, 0));
    step("ret_stalled", mk(0, 0, 32'h0, 0, 1, 32'h600, 1, 0, 0, 0));
    step("ret_after", mk(1, 0, 32'h0, 0, 1, 32'h1010, 1, 0, 1, 0));
    step("pre_rst1", mk(1, 1, 32'h700, 1, 0, 32'h700, 1, 0, 0, 0));
    step("pre_rst2", mk(1, 1, 32'h900, 1, 0, 32'h900, 1, 0, 0, 0));
`else
    step("nras_bl", mk(1, 1, 32'h40, 1, 0, 32'h40, 1, 0, 1, 0));
    step("nras_ret", mk(1, 0, 32'h0, 0, 1, 32'h44, 1, 0, 1, 0));
    step("nras_ret_stall", mk(0, 0, 32'h0, 0, 1, 32'h44, 1, 0, 1, 0));
    step("nras_bl_ret", mk(0, 1, 32'h80, 1, 1, 32'h80, 1, 0, 1, 0));
`endif

    bif.enable = 1'b1; bif.redirect_valid = 1'b0; bif.link = 1'b0; bif.ret = 1'b0;
    reset = 1'b0;
    #2;
    check_out("async_rst", mk(0, 0, 0, 0, 0, 32'h100, 0, 0, 1, 0));
    @(posedge clk);
    #1;
    check_out("rst_held", mk(0, 0, 0, 0, 0, 32'h100, 0, 0, 1, 0));
    reset = 1'b1;
    step("post_rst_ret", mk(1, 0, 32'h0, 0, 1, 32'h104, 0, RAS, 1, 0));
    step("post_rst_seq", mk(1, 0, 32'h0, 0, 0, 32'h108, 0, 0, 1, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
